serial_receptor: RTL and testbench
==================================

// Module: serial_receptor
// PURPOSE
//   Serial-to-parallel receiver at the far end of the S_OUT serial line of the
//   4-bit shift register.
//   - Detects a start bit, shifts in WIDTH data bits in the selected order,
//     checks an even-parity bit, and presents the word on Q with a 1-cycle
//     VALID strobe.
//   - Lets the team check a transmitted word end-to-end against the parallel
//     D loaded at the sender.
// PARAMETERS
//   WIDTH  4  data bits per frame (>=2); bit counter is $clog2(WIDTH)+1 bits
// PORTS
//   CLK    input   1      clock, all state updates on rising edge
//   RESET  input   1      asynchronous, active-high reset
//   ENB    input   1      bit-enable; S_IN sampled only on edges with ENB=1
//   DIR    input   1      bit order: 0 = LSB first, 1 = MSB first
//   S_IN   input   1      serial line (driven from transmitter S_OUT)
//   Q      output  WIDTH  last correctly received word
//   VALID  output  1      1-cycle strobe: Q updated with a good frame
//   PERR   output  1      1-cycle strobe: frame done, parity failed
//   BUSY   output  1      1 while a frame is in progress (DATA/PARITY)
// BEHAVIOUR
//   Frame on S_IN, one bit per ENB=1 edge:
//     start(1), WIDTH data bits, parity bit P.
//     P makes the total number of 1s in data+P even.
//   Idle line level is 0.
//   Reset (async, any time incl. mid-frame):
//     state=IDLE, shift reg=0, count=0, Q=0, VALID=0, PERR=0, BUSY=0.
//   ENB=0: state, count and shift reg hold. VALID and PERR still clear after
//     one cycle.
//   FSM (transitions only on edges with ENB=1):
//     IDLE:   S_IN=1 -> DATA, count=0, latch DIR into dir_r.
//             S_IN=0 -> stay IDLE.
//     DATA:   store S_IN. dir_r=0: bit k goes to position k.
//             dir_r=1: bit k goes to position WIDTH-1-k.
//             count++. After bit WIDTH-1 -> PARITY.
//     PARITY: compute ^{data,S_IN}.
//             0 -> Q<=data, VALID<=1.
//             1 -> Q holds, PERR<=1.
//             Then -> IDLE.
//   DIR changes mid-frame are ignored; only dir_r (latched at start) is used.
//   BUSY is registered: 1 in DATA and PARITY states, 0 in IDLE.
//   Latency: VALID/PERR rise on the edge that samples P. The word is on Q in
//     the same cycle as VALID. VALID/PERR are cleared on the next edge
//     regardless of ENB.
//   Back-to-back frames:
//     - The first ENB edge after P is handled in IDLE.
//     - A start bit there begins the next frame.
//     - No gap bits are required beyond that single IDLE sample.
//   VALID and PERR are never both 1. Q changes only together with VALID=1.
// TESTING
//   1 RESET pulse mid-frame (after 2 data bits)
//     -> Q=0, VALID=0, BUSY=0 immediately.
//     -> A subsequent full frame is received correctly.
//   2 DIR=0, ENB=1, S_IN = 1,1,0,1,1,P=1
//     -> Q=4'hD, VALID=1 for one cycle, PERR=0.
//   3 DIR=1, same stream 1,1,0,1,1,1
//     -> Q=4'hB, VALID=1.
//   4 DIR=0, stream 1,0,0,0,1,P=0 (bad parity), Q previously 4'hD
//     -> PERR=1 for one cycle, VALID=0, Q stays 4'hD.
//   5 Two back-to-back frames 4'h3 then 4'hC (DIR=0), ENB=1 throughout
//     -> VALID pulses exactly 6 cycles apart; Q=4'h3 then 4'hC.
//   6 Frame 4'h5 with ENB=0 for 3 cycles inserted between data bits,
//     and DIR toggled mid-frame
//     -> Q=4'h5, VALID once, BUSY high throughout the stall.

Source files
------------

// File: rtl/serial_receptor.sv
// Serial-to-parallel receiver: start bit, WIDTH data bits (selectable order),
// even parity; presents the word on Q with a one-cycle VALID or PERR strobe.
module serial_receptor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             PERR,
  output logic             BUSY
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             busy_q, busy_d;
  int unsigned      pos;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      q_q     <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      q_q     <= q_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      busy_q  <= busy_d;
    end
  end

  // Destination bit position of the current data bit, honouring the order latched at start.
  always_comb begin
    pos = dir_q ? (WIDTH - 1 - 32'(cnt_q)) : 32'(cnt_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    q_d     = q_q;
    dir_d   = dir_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;

    if (ENB) begin
      unique case (state_q)
        IDLE: begin
          if (S_IN) begin
            state_d = DATA;
            cnt_d   = '0;
            dir_d   = DIR;
          end
        end
        DATA: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i == pos) shift_d[i] = S_IN;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = PARITY;
        end
        PARITY: begin
          if (^{shift_q, S_IN}) begin
            perr_d = 1'b1;
          end else begin
            q_d     = shift_q;
            valid_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign Q     = q_q;
  assign VALID = valid_q;
  assign PERR  = perr_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_serial_receptor.sv
// Scoreboard bench for serial_receptor: frames are driven bit by bit and the
// expected strobe/word is queued, then popped when VALID or PERR appears.
module tb_serial_receptor;

  localparam int unsigned W = 4;

  logic         CLK = 1'b0;
  logic         RESET, ENB, DIR, S_IN;
  logic [W-1:0] Q;
  logic         VALID, PERR, BUSY;

  typedef struct {
    logic         valid;
    logic [W-1:0] q;
  } exp_t;

  exp_t        sb[$];
  int unsigned vcyc[$];
  int unsigned cycle = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [W-1:0] prev_q = '0;

  serial_receptor #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .ENB   (ENB),
    .DIR   (DIR),
    .S_IN  (S_IN),
    .Q     (Q),
    .VALID (VALID),
    .PERR  (PERR),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Output monitor: every strobe must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (RESET) begin
      prev_q = '0;
    end else begin
      if (VALID || PERR) begin
        check("strobe_excl", 32'(VALID && PERR), 0);
        if (sb.size() == 0) begin
          check("unexpected_strobe", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_kind_valid", 32'(VALID), 32'(e.valid));
          check("strobe_kind_perr", 32'(PERR), 32'(!e.valid));
          check("q_word", 32'(Q), 32'(e.q));
        end
        if (VALID) vcyc.push_back(cycle);
      end
      if (!VALID) check("q_hold", 32'(Q), 32'(prev_q));
      prev_q = Q;
    end
  end

  task automatic drive_bit(input logic b);
    @(posedge CLK);
    #1;
    ENB  = 1'b1;
    S_IN = b;
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      ENB  = 1'b0;
      S_IN = 1'($urandom);
      DIR  = ~DIR;
      check("busy_stall", 32'(BUSY), 1);
    end
  endtask

  // seq[k] is the k-th transmitted data bit.
  task automatic send_frame(input logic [W-1:0] seq, input logic p, input logic dir,
                            input int stall_at);
    DIR = dir;
    drive_bit(1'b1);
    for (int k = 0; k < int'(W); k++) begin
      drive_bit(seq[k]);
      if (k == stall_at) stall(3);
    end
    drive_bit(p);
  endtask

  task automatic expect_strobe(input logic valid, input logic [W-1:0] q);
    exp_t e;
    e.valid = valid;
    e.q     = q;
    sb.push_back(e);
  endtask

  task automatic drain();
    int budget;
    drive_bit(1'b0);
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge CLK);
      budget--;
    end
    check("drain_timeout", sb.size(), 0);
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    RESET = 1'b1;
    ENB   = 1'b0;
    DIR   = 1'b0;
    S_IN  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_q", 32'(Q), 0);
    check("rst_valid", 32'(VALID), 0);
    check("rst_perr", 32'(PERR), 0);
    check("rst_busy", 32'(BUSY), 0);
    RESET = 1'b0;
    repeat (2) @(posedge CLK);

    // LSB first, stream 1,0,1,1 P=1 -> 4'hD
    expect_strobe(1'b1, 4'hD);
    send_frame(4'b1101, 1'b1, 1'b0, -1);
    drain();
    check("t2_q", 32'(Q), 32'hD);

    // Bad parity: data 0,0,0,1 P=0 -> PERR, Q holds 4'hD
    expect_strobe(1'b0, 4'hD);
    send_frame(4'b1000, 1'b0, 1'b0, -1);
    drain();
    check("t4_q_hold", 32'(Q), 32'hD);

    // Async reset mid-frame after two data bits
    DIR = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(posedge CLK);
    #2;
    ENB   = 1'b0;
    RESET = 1'b1;
    #1;
    check("midrst_q", 32'(Q), 0);
    check("midrst_valid", 32'(VALID), 0);
    check("midrst_busy", 32'(BUSY), 0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;

    // MSB first, same stream -> 4'hB
    expect_strobe(1'b1, 4'hB);
    send_frame(4'b1101, 1'b1, 1'b1, -1);
    drain();
    check("t3_q", 32'(Q), 32'hB);

    // Back-to-back 4'h3 then 4'hC, LSB first
    vcyc.delete();
    expect_strobe(1'b1, 4'h3);
    expect_strobe(1'b1, 4'hC);
    send_frame(4'h3, 1'b0, 1'b0, -1);
    send_frame(4'hC, 1'b0, 1'b0, -1);
    drain();
    check("b2b_count", vcyc.size(), 2);
    if (vcyc.size() == 2) check("b2b_gap", vcyc[1] - vcyc[0], 6);
    check("t5_q", 32'(Q), 32'hC);

    // 4'h5 with a 3-cycle ENB stall after data bit 1 and DIR toggling
    vcyc.delete();
    expect_strobe(1'b1, 4'h5);
    send_frame(4'h5, 1'b0, 1'b0, 1);
    drain();
    check("stall_valid_count", vcyc.size(), 1);
    check("t6_q", 32'(Q), 32'h5);
    check("idle_busy", 32'(BUSY), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
